// File: rtl/inst_queue.sv
// Instruction/PC FIFO between fetch and decode. Circular buffer with registered
// head/tail/count; flush clears all state synchronously with top priority.
module inst_queue #(
    parameter int QUEUE_LOG2 = 4,
    parameter int INST_W     = 32,
    parameter int ADDR_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [INST_W-1:0]     in_inst,
    input  logic [ADDR_W-1:0]     in_pc,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [INST_W-1:0]     out_inst,
    output logic [ADDR_W-1:0]     out_pc,
    input  logic                  dec_ready,
    output logic [QUEUE_LOG2:0]   count
);

    localparam int unsigned DEPTH = 1 << QUEUE_LOG2;
    localparam logic [QUEUE_LOG2:0] FULL_COUNT = {1'b1, {QUEUE_LOG2{1'b0}}};

    logic [INST_W-1:0]     mem_inst [DEPTH];
    logic [ADDR_W-1:0]     mem_pc   [DEPTH];
    logic [QUEUE_LOG2-1:0] head;
    logic [QUEUE_LOG2-1:0] tail;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    always_comb begin
        full      = (count == FULL_COUNT);
        empty     = (count == '0);
        in_ready  = !full;
        out_valid = !empty;
        push      = in_valid && !full && !flush;
        pop       = !empty && dec_ready && !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[tail] <= in_inst;
            mem_pc[tail]   <= in_pc;
        end
    end

    always_comb begin
        out_inst = '0;
        out_pc   = '0;
        if (!empty) begin
            out_inst = mem_inst[head];
            out_pc   = mem_pc[head];
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus random traffic,
// compared against a queue-based FIFO reference model.
module tb_inst_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        dec_ready = 1'b0;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;
    ent_t q[$];

    inst_queue #(.QUEUE_LOG2(4), .INST_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .dec_ready(dec_ready), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        ent_t h;
        h = (q.size() > 0) ? q[0] : '0;
        chk({tag, ".count"},     64'(count),     64'(q.size()));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
        chk({tag, ".in_ready"},  64'(in_ready),  64'(q.size() < 16));
        chk({tag, ".out_inst"},  64'(out_inst),  64'(h.inst));
        chk({tag, ".out_pc"},    64'(out_pc),    64'(h.pc));
    endtask

    // One clock: drive inputs, advance the model by FIFO rules, check after the edge.
    task automatic step(input string tag, input logic iv, input logic [31:0] inst,
                        input logic [31:0] pc, input logic dr, input logic fl);
        bit do_push, do_pop;
        in_valid  = iv;
        in_inst   = inst;
        in_pc     = pc;
        dec_ready = dr;
        flush     = fl;
        do_push = iv && (q.size() < 16) && !fl;
        do_pop  = dr && (q.size() > 0) && !fl;
        @(posedge clk);
        #1;
        if (fl) q.delete();
        else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back('{inst: inst, pc: pc});
        end
        chk_model(tag);
    endtask

    initial begin
        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        chk("in_reset.count", 64'(count), 0);
        chk("in_reset.out_valid", 64'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_model("idle");
        chk("idle.out_inst", 64'(out_inst), 0);

        // Single pass-through
        step("pt_push", 1, 32'h0050_0093, 32'h0, 0, 0);
        chk("pt.out_inst", 64'(out_inst), 64'h0050_0093);
        chk("pt.count", 64'(count), 1);
        step("pt_pop", 0, '0, '0, 1, 0);
        chk("pt_pop.out_valid", 64'(out_valid), 0);

        // Fill to full, reject 17th, drain in order
        for (int i = 0; i < 16; i++) step("fill", 1, $urandom, 32'(i * 4), 0, 0);
        chk("full.count", 64'(count), 16);
        chk("full.in_ready", 64'(in_ready), 0);
        step("push17", 1, 32'hDEAD_BEEF, 32'h40, 0, 0);
        chk("push17.count", 64'(count), 16);
        for (int i = 0; i < 16; i++) begin
            chk("drain.out_pc", 64'(out_pc), 64'(i * 4));
            step("drain", 0, '0, '0, 1, 0);
        end
        chk("drained.out_valid", 64'(out_valid), 0);

        // Wrap with simultaneous push/pop at count 15
        for (int i = 0; i < 15; i++) step("preload", 1, $urandom, 32'(32'h1000 + i * 4), 0, 0);
        for (int i = 0; i < 20; i++) begin
            chk("wrap.out_pc", 64'(out_pc), 64'(32'h1000 + i * 4));
            step("wrap", 1, $urandom, 32'(32'h1000 + (15 + i) * 4), 1, 0);
        end
        chk("wrap.count", 64'(count), 15);

        // Full with pop: push rejected, next cycle accepted
        step("tofull", 1, $urandom, 32'h2000, 0, 0);
        chk("tofull.count", 64'(count), 16);
        step("full_pop", 1, 32'hBAD0_0001, 32'h2004, 1, 0);
        chk("full_pop.count", 64'(count), 15);
        chk("full_pop.in_ready", 64'(in_ready), 1);
        step("retry", 1, 32'h600D_0001, 32'h2004, 1, 0);
        chk("retry.count", 64'(count), 15);

        // Flush with push and pop in the same cycle
        step("pre_flush", 0, '0, '0, 0, 1);
        for (int i = 0; i < 7; i++) step("load7", 1, $urandom, 32'(32'h3000 + i * 4), 0, 0);
        chk("load7.count", 64'(count), 7);
        step("flush", 1, 32'h1111_1111, 32'h3100, 1, 1);
        chk("flush.count", 64'(count), 0);
        chk("flush.in_ready", 64'(in_ready), 1);
        step("post_flush", 1, 32'h2222_2222, 32'h3200, 0, 0);
        chk("post_flush.out_pc", 64'(out_pc), 64'h3200);

        // Asynchronous reset between edges
        for (int i = 0; i < 8; i++) step("load9", 1, $urandom, 32'(32'h4000 + i * 4), 0, 0);
        chk("load9.count", 64'(count), 9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.count", 64'(count), 0);
        chk("async_rst.out_valid", 64'(out_valid), 0);
        chk("async_rst.out_inst", 64'(out_inst), 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic with phases biased toward filling and draining
        for (int i = 0; i < 600; i++) begin
            bit fill_phase;
            fill_phase = ((i / 50) % 2) == 0;
            step("rand",
                 fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 $urandom, $urandom,
                 fill_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 59) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Instruction FIFO between the fetcher and the decode stage of the Tomasulo core.
- Buffers fetched instruction/PC pairs so that fetch can run ahead while decode stalls on a full RS, ROB or LSB.
- Presents the oldest entry to decode with a valid/ready handshake.
- Discards all contents on a ROB misprediction flush.

Parameters:
- QUEUE_LOG2, 4, log2 of entry count (default 16 entries)
- INST_W, 32, instruction width (matches `INSTRUCTION_WIDTH)
- ADDR_W, 32, PC width (matches `DATA_WIDTH)

Ports:
- clk  input  1  core clock; all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  misprediction flush from ROB; synchronous, highest priority
- in_valid  input  1  fetcher presents an instruction this cycle
- in_inst  input  INST_W  fetched instruction word
- in_pc  input  ADDR_W  PC of in_inst
- in_ready  output  1  queue can accept a push this cycle (= !full)
- out_valid  output  1  head entry valid (= !empty)
- out_inst  output  INST_W  head instruction, to decode inst
- out_pc  output  ADDR_W  head PC, to decode current_pc
- dec_ready  input  1  decode consumes head this cycle (drives decode ena path)
- count  output  QUEUE_LOG2+1  number of occupied entries

Behaviour:
- Storage:
  - 2^QUEUE_LOG2 entries of {inst, pc}, circular.
  - Registered pointers head and tail, each QUEUE_LOG2 bits; they wrap naturally modulo depth.
  - Registered count, 0..2^QUEUE_LOG2.
- Reset (rst_n low, asynchronous):
  - head=0, tail=0, count=0.
  - Outputs: in_ready=1, out_valid=0, out_inst=0, out_pc=0, count=0.
  - Entry contents are don't-care.
  - Reset asserted mid-operation discards everything immediately, without waiting for a clock edge.
- Derived signals:
  - full = (count == 2^QUEUE_LOG2); empty = (count == 0).
  - in_ready = !full. It does not depend on dec_ready, so there is no combinational path from decode to fetch.
  - out_valid = !empty.
  - out_inst/out_pc = entry[head] when !empty, else 0. These are driven from storage registers, with no combinational path from in_*.
- Push: on posedge, if in_valid && in_ready && !flush, write entry[tail] and tail <= tail+1.
- Pop: on posedge, if out_valid && dec_ready && !flush, head <= head+1.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push+pop, not full, not empty: both occur; count unchanged.
- Full with dec_ready: the pop occurs and the push is rejected (in_ready was 0). The fetcher retries next cycle.
- Empty with in_valid and dec_ready: the push occurs and there is no pop. There is no bypass; an entry becomes visible one cycle after push. Minimum latency from push to out_valid is 1 cycle.
- Flush:
  - On posedge with flush=1: head=0, tail=0, count=0.
  - Push and pop in the same cycle are ignored, including an in_valid instruction, which is dropped.
  - The cycle after flush: out_valid=0 and in_ready=1.
- Wrap-around: pointer increments past 2^QUEUE_LOG2-1 return to 0. Order is strictly FIFO across the wrap.
- in_valid while !in_ready: ignored; no state change.
- X-safety: out_inst and out_pc never expose stale entries when empty (forced to 0). Decode then sees opcode 0 and decodes NOP.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, then release -> count=0, out_valid=0, in_ready=1, out_inst=0.
- Single pass-through: push inst 0x00500093 with pc 0x0, dec_ready=0 -> next cycle out_valid=1, out_inst=0x00500093, out_pc=0x0, count=1. Raise dec_ready for 1 cycle -> count=0, out_valid=0.
- Fill to full: 16 pushes with pc 0x0..0x3C step 4, dec_ready=0 -> count=16, in_ready=0. A 17th push with pc 0x40 is ignored. Then drain with dec_ready=1 -> out_pc sequence is 0x0..0x3C in order.
- Wrap and simultaneous push/pop: preload 15 entries, then run 20 cycles of in_valid=1 and dec_ready=1 -> count stays 15. The popped PC sequence is continuous across pointer wrap.
- Full with pop: at count=16, assert dec_ready=1 and in_valid=1 -> count=15 and the new instruction is not stored. Next cycle in_ready=1 and the push succeeds -> count=15 again.
- Flush and reset mid-operation: with count=7, assert flush together with in_valid and dec_ready -> next cycle count=0, out_valid=0, and the following push appears at head. Separately, with count=9, drop rst_n between edges -> count=0 and out_valid=0 immediately.
